// File: rtl/bitpack_batch_seq.sv
// Batch sequencer for the bitstream compute circuit: per job it loads SNG config words,
// runs the bitstreams for SIZE cycles, then writes back the counter chain.
module bitpack_batch_seq #(
   parameter int SRC_N = 4,
   parameter int DST_N = 2,
   parameter int CNT_W = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 GO,
   output logic                 DONE,
   output logic                 ERR,
   input  logic [31:0]          SRC,
   input  logic [31:0]          DST,
   input  logic [CNT_W-1:0]     SIZE,
   input  logic [CNT_W-1:0]     BATCH,
   output logic [31:0]          READ_ADDR,
   output logic [15:0]          READ_COUNT,
   output logic                 READ_REQ,
   input  logic                 READ_BUSY,
   input  logic [31:0]          READ_DATA,
   input  logic                 READ_VALID,
   output logic                 READ_READY,
   output logic [31:0]          WRITE_ADDR,
   output logic [15:0]          WRITE_COUNT,
   output logic                 WRITE_REQ,
   input  logic                 WRITE_BUSY,
   output logic [31:0]          WRITE_DATA,
   output logic                 WRITE_VALID,
   input  logic                 WRITE_READY,
   output logic [31:0]          SNG_DATA,
   output logic [SRC_N-1:0]     COMP_WE,
   output logic [SRC_N-1:0]     SEED_WE,
   output logic                 PROC_EN,
   output logic                 CNT_CLR,
   input  logic [31:0]          DST_DATA,
   output logic                 DST_SHIFT
);

   localparam int WORDS = 2 * SRC_N;
   localparam int WW    = $clog2(WORDS + 1);
   localparam int BW    = $clog2(DST_N + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RREQ, S_READ, S_PROC, S_WREQ, S_WRITE, S_NEXT, S_FINI
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      ra_q, ra_d, wa_q, wa_d;
   logic [CNT_W-1:0] jobs_q, jobs_d, len_q, len_d, j_q, j_d, c_q, c_d;
   logic [WW-1:0]    w_q, w_d;
   logic [BW-1:0]    b_q, b_d;
   logic             err_q, err_d;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         wa_q    <= '0;
         jobs_q  <= '0;
         len_q   <= '0;
         j_q     <= '0;
         c_q     <= '0;
         w_q     <= '0;
         b_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         wa_q    <= wa_d;
         jobs_q  <= jobs_d;
         len_q   <= len_d;
         j_q     <= j_d;
         c_q     <= c_d;
         w_q     <= w_d;
         b_q     <= b_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      wa_d    = wa_q;
      jobs_d  = jobs_q;
      len_d   = len_q;
      j_d     = j_q;
      c_d     = c_q;
      w_d     = w_q;
      b_d     = b_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: if (GO) begin
            ra_d    = SRC;
            wa_d    = DST;
            jobs_d  = (BATCH == '0) ? CNT_W'(1) : BATCH;
            len_d   = SIZE;
            err_d   = 1'b0;
            j_d     = '0;
            state_d = S_RREQ;
         end
         S_RREQ: if (!READ_BUSY) begin
            w_d     = '0;
            state_d = S_READ;
         end
         S_READ: if (READ_VALID) begin
            w_d = w_q + WW'(1);
            if (w_q == WW'(WORDS - 1)) begin
               c_d = '0;
               // zero-length job: counters were just cleared, so they report 0
               if (len_q == '0) begin
                  err_d   = 1'b1;
                  state_d = S_WREQ;
               end else begin
                  state_d = S_PROC;
               end
            end
         end
         S_PROC: begin
            c_d = c_q + CNT_W'(1);
            if (c_q == len_q - CNT_W'(1)) state_d = S_WREQ;
         end
         S_WREQ: if (!WRITE_BUSY) begin
            b_d     = '0;
            state_d = S_WRITE;
         end
         S_WRITE: if (WRITE_READY) begin
            b_d = b_q + BW'(1);
            if (b_q == BW'(DST_N - 1)) state_d = S_NEXT;
         end
         S_NEXT: begin
            ra_d    = ra_q + 32'(8 * SRC_N);
            wa_d    = wa_q + 32'(4 * DST_N);
            j_d     = j_q + CNT_W'(1);
            state_d = (j_q + CNT_W'(1) < jobs_q) ? S_RREQ : S_FINI;
         end
         S_FINI: if (!GO) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      DONE        = (state_q == S_IDLE);
      READ_ADDR   = ra_q;
      READ_COUNT  = 16'(WORDS);
      READ_REQ    = (state_q == S_RREQ) && !READ_BUSY;
      READ_READY  = (state_q == S_READ);
      WRITE_ADDR  = wa_q;
      WRITE_COUNT = 16'(DST_N);
      WRITE_REQ   = (state_q == S_WREQ) && !WRITE_BUSY;
      WRITE_VALID = (state_q == S_WRITE);
      WRITE_DATA  = (state_q == S_WRITE) ? DST_DATA : '0;
      DST_SHIFT   = (state_q == S_WRITE) && WRITE_READY;
      PROC_EN     = (state_q == S_PROC);
      CNT_CLR     = (state_q == S_READ) && READ_VALID && (w_q == WW'(WORDS - 1));
      COMP_WE     = '0;
      SEED_WE     = '0;
      // even words load comparators, odd words load seeds
      for (int i = 0; i < SRC_N; i++) begin
         COMP_WE[i] = (state_q == S_READ) && READ_VALID && (w_q == WW'(2 * i));
         SEED_WE[i] = (state_q == S_READ) && READ_VALID && (w_q == WW'(2 * i + 1));
      end
   end

   assign ERR      = err_q;
   assign SNG_DATA = READ_DATA;

endmodule

// File: tb/tb_bitpack_batch_seq.sv
// Randomized bench for bitpack_batch_seq: a job-level model predicts addresses, strobe
// order, word data, PROC length and beat counts; a negedge monitor checks every event.
module tb_bitpack_batch_seq;
   localparam int SRC_N = 4, DST_N = 2, CNT_W = 32, WORDS = 2 * SRC_N;

   logic CLK, RST, GO, DONE, ERR;
   logic [31:0] SRC, DST;
   logic [CNT_W-1:0] SIZE, BATCH;
   logic [31:0] READ_ADDR, READ_DATA, WRITE_ADDR, WRITE_DATA, SNG_DATA, DST_DATA;
   logic [15:0] READ_COUNT, WRITE_COUNT;
   logic READ_REQ, READ_BUSY, READ_VALID, READ_READY;
   logic WRITE_REQ, WRITE_BUSY, WRITE_VALID, WRITE_READY;
   logic [SRC_N-1:0] COMP_WE, SEED_WE;
   logic PROC_EN, CNT_CLR, DST_SHIFT;

   bitpack_batch_seq #(.SRC_N(SRC_N), .DST_N(DST_N), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .GO(GO), .DONE(DONE), .ERR(ERR), .SRC(SRC), .DST(DST),
      .SIZE(SIZE), .BATCH(BATCH), .READ_ADDR(READ_ADDR), .READ_COUNT(READ_COUNT),
      .READ_REQ(READ_REQ), .READ_BUSY(READ_BUSY), .READ_DATA(READ_DATA),
      .READ_VALID(READ_VALID), .READ_READY(READ_READY), .WRITE_ADDR(WRITE_ADDR),
      .WRITE_COUNT(WRITE_COUNT), .WRITE_REQ(WRITE_REQ), .WRITE_BUSY(WRITE_BUSY),
      .WRITE_DATA(WRITE_DATA), .WRITE_VALID(WRITE_VALID), .WRITE_READY(WRITE_READY),
      .SNG_DATA(SNG_DATA), .COMP_WE(COMP_WE), .SEED_WE(SEED_WE), .PROC_EN(PROC_EN),
      .CNT_CLR(CNT_CLR), .DST_DATA(DST_DATA), .DST_SHIFT(DST_SHIFT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] rdw(input int unsigned k);
      return (k * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction
   function automatic logic [31:0] wrw(input int unsigned k);
      return (k * 32'h7F4A7C15) + 32'h00001357;
   endfunction

   // job-level model of the current run
   logic [31:0] m_src, m_dst;
   int unsigned m_size, m_jobs;
   int unsigned run_id = 0, seen_id = 0;
   int unsigned n_rreq, n_wreq, n_clr, n_stb, n_beat, n_proc;
   int unsigned rd_ord = 0, wr_ord = 0, rd_nx = 0, wr_nx = 0, cyc_n = 0;
   int t_rreq0;
   int bp = 0, busy_left = 0;

   assign READ_DATA = rdw(rd_ord);
   assign DST_DATA  = wrw(wr_ord);

   logic [SRC_N-1:0] ec, es;
   logic [31:0] ea;
   int unsigned k;

   always @(negedge CLK) begin
      cyc_n++;
      if (seen_id != run_id) begin
         seen_id = run_id;
         n_rreq = 0; n_wreq = 0; n_clr = 0; n_stb = 0; n_beat = 0; n_proc = 0;
         t_rreq0 = -1;
      end
      chk("excl", {62'd0, READ_REQ & WRITE_REQ, PROC_EN & DST_SHIFT}, 64'd0);
      if (READ_REQ) begin
         ea = m_src + 32'(8 * SRC_N) * 32'(n_rreq);
         chk("rreq_busy", READ_BUSY, 0);
         chk("raddr", READ_ADDR, ea);
         chk("rcount", READ_COUNT, WORDS);
         if (n_rreq == 0) t_rreq0 = int'(cyc_n);
         n_rreq++;
      end
      if (CNT_CLR) n_clr++;
      if (READ_VALID && READ_READY) begin
         k = n_stb;
         ec = '0; es = '0;
         if (k % 2 == 0) ec[(k % WORDS) / 2] = 1'b1;
         else            es[(k % WORDS) / 2] = 1'b1;
         chk("strobe", {COMP_WE, SEED_WE}, {ec, es});
         chk("sng_data", SNG_DATA, rdw(rd_ord));
         chk("cnt_clr", CNT_CLR, (k % WORDS) == WORDS - 1);
         n_stb++;
         rd_nx = rd_ord + 1;
      end else begin
         chk("no_strobe", {COMP_WE, SEED_WE, CNT_CLR}, 0);
      end
      if (PROC_EN) n_proc++;
      if (WRITE_REQ) begin
         ea = m_dst + 32'(4 * DST_N) * 32'(n_wreq);
         chk("wreq_busy", WRITE_BUSY, 0);
         chk("proc_len", n_proc, m_size);
         chk("waddr", WRITE_ADDR, ea);
         chk("wcount", WRITE_COUNT, DST_N);
         n_proc = 0;
         n_wreq++;
      end
      if (WRITE_VALID) chk("wdata", WRITE_DATA, wrw(wr_ord));
      chk("shift", DST_SHIFT, WRITE_VALID && WRITE_READY);
      if (WRITE_VALID && WRITE_READY) begin
         n_beat++;
         wr_nx = wr_ord + 1;
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
      rd_ord = rd_nx;
      wr_ord = wr_nx;
      READ_BUSY = 1'b0; READ_VALID = 1'b1; WRITE_BUSY = 1'b0; WRITE_READY = 1'b1;
      if (bp == 1) begin
         READ_BUSY   = ($urandom_range(0, 3) == 0);
         READ_VALID  = $urandom_range(0, 1) == 1;
         WRITE_BUSY  = ($urandom_range(0, 3) == 0);
         WRITE_READY = ($urandom_range(0, 2) != 0);
      end else if (bp == 2) begin
         READ_BUSY = (busy_left > 0);
         if (busy_left > 0) busy_left--;
      end
   endtask

   task automatic start_job(input logic [31:0] src, input logic [31:0] dst,
                            input int unsigned size, input int unsigned batch, input int mode);
      m_src = src; m_dst = dst; m_size = size; m_jobs = (batch == 0) ? 1 : batch;
      bp = mode;
      run_id++;
      SRC = src; DST = dst; SIZE = size; BATCH = batch; GO = 1'b1;
      if (mode == 2) begin
         READ_BUSY = 1'b1;
         busy_left = 5;
      end
      cyc();
      // inputs are latched at GO, so scrambling them must not matter
      SRC = $urandom; DST = $urandom; SIZE = $urandom; BATCH = $urandom;
   endtask

   task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int unsigned size,
                          input int unsigned batch, input int mode, output int delay);
      int guard, t_go;
      t_go = int'(cyc_n);
      start_job(src, dst, size, batch, mode);
      guard = 0;
      while (n_beat < DST_N * m_jobs && guard < 5000) begin
         cyc();
         guard++;
      end
      chk("timeout", guard < 5000, 1);
      repeat (4) cyc();
      chk("fini_done", DONE, 0);
      chk("n_rreq", n_rreq, m_jobs);
      chk("n_wreq", n_wreq, m_jobs);
      chk("n_clr", n_clr, m_jobs);
      chk("n_strobe", n_stb, WORDS * m_jobs);
      chk("n_beat", n_beat, DST_N * m_jobs);
      chk("err", ERR, m_size == 0);
      GO = 1'b0;
      cyc();
      chk("idle_done", DONE, 1);
      delay = t_rreq0 - t_go;
   endtask

   int d0, d1, dx, guard;

   initial begin
      RST = 1'b1; GO = 1'b0; SRC = '0; DST = '0; SIZE = '0; BATCH = '0;
      READ_BUSY = 1'b0; READ_VALID = 1'b0; WRITE_BUSY = 1'b0; WRITE_READY = 1'b0;
      m_src = '0; m_dst = '0; m_size = 0; m_jobs = 1;
      #12;
      chk("rst_state", {DONE, ERR, READ_REQ, WRITE_REQ, PROC_EN, CNT_CLR, READ_READY,
                        WRITE_VALID, DST_SHIFT, COMP_WE, SEED_WE}, {1'b1, 16'd0});
      chk("rst_addr", {READ_ADDR, WRITE_ADDR}, 0);
      cyc();
      RST = 1'b0;
      cyc();

      run_job(32'h100, 32'h200, 16, 1, 0, d0);
      run_job(32'h1000, 32'h2000, 5, 3, 0, dx);
      run_job(32'h3000, 32'h4000, 7, 0, 0, dx);
      run_job(32'h5000, 32'h6000, 0, 2, 1, dx);
      run_job(32'h7000, 32'h8000, 9, 1, 2, d1);
      chk("rreq_delay", d1, d0 + 5);
      run_job(32'hFFFFFFF0, 32'hFFFFFFFC, 3, 2, 1, dx);

      // abort in the middle of PROC, then a clean job must still work
      start_job(32'hA000, 32'hB000, 16, 1, 0);
      guard = 0;
      while (n_proc < 7 && guard < 200) begin
         cyc();
         guard++;
      end
      chk("mid_proc_wait", guard < 200, 1);
      RST = 1'b1;
      GO  = 1'b0;
      cyc();
      chk("abort_state", {DONE, ERR, READ_REQ, WRITE_REQ, PROC_EN, CNT_CLR, READ_READY,
                          WRITE_VALID, DST_SHIFT, COMP_WE, SEED_WE}, {1'b1, 16'd0});
      repeat (3) cyc();
      chk("abort_no_req", {n_rreq, n_wreq}, {32'd1, 32'd0});
      RST = 1'b0;
      cyc();
      run_job(32'hC000, 32'hD000, 16, 1, 0, dx);

      for (int i = 0; i < 20; i++)
         run_job($urandom, $urandom, $urandom_range(0, 24), $urandom_range(0, 4),
                 ($urandom_range(0, 3) == 0) ? 0 : 1, dx);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bitpack_batch_seq.md
Name: bitpack_batch_seq

Overview:
- Parametrised successor to the single-job bitstream wrapper controller; runs BATCH back-to-back jobs per GO.
- Each job does: DMA-read SNG config words → run SIZE bitstream cycles → DMA-write counter results. Source and destination addresses advance automatically between jobs.
- Drives the SNG and counter arrays through strobes. Sits between AXI_CTRL/AXI_FIFO and the generated compute circuit.

Parameters:
- SRC_N, 4, number of SNGs; each takes 2 words, comparator then seed.
- DST_N, 2, number of ones-counters; results form a shift chain.
- CNT_W, 32, width of the SIZE and BATCH counters.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- GO  in  1  start level from AXI_CTRL
- DONE  out  1  idle/ready indicator
- ERR  out  1  sticky error, cleared on next accepted GO
- SRC, DST  in  32 each  base byte addresses of job 0
- SIZE  in  CNT_W  bitstream length per job
- BATCH  in  CNT_W  job count; 0 is treated as 1
- READ_ADDR  out  32; READ_COUNT  out  16; READ_REQ  out  1; READ_BUSY  in  1
- READ_DATA  in  32; READ_VALID  in  1; READ_READY  out  1
- WRITE_ADDR  out  32; WRITE_COUNT  out  16; WRITE_REQ  out  1; WRITE_BUSY  in  1
- WRITE_DATA  out  32; WRITE_VALID  out  1; WRITE_READY  in  1
- SNG_DATA  out  32  READ_DATA forwarded to the SNGs
- COMP_WE, SEED_WE  out  SRC_N each  one-hot write strobes
- PROC_EN  out  1  enables SNGs and counters
- CNT_CLR  out  1  clears the counters before each job's PROC
- DST_DATA  in  32  head of the counter result chain
- DST_SHIFT  out  1  advances the chain

Behaviour:
- Reset: asynchronous and active-high.
  - State→IDLE; all counters and address registers→0; ERR=0.
  - All strobes, REQ and VALID/READY outputs are 0; DONE=1 in IDLE.
  - Reset asserted mid-job aborts immediately; no further REQ is issued.
- States: IDLE, RREQ, READ, PROC, WREQ, WRITE, NEXT, FINI.
- IDLE: DONE=1. On GO=1:
  - latch addresses: ra←SRC, wa←DST;
  - latch jobs←(BATCH==0 ? 1 : BATCH) and len←SIZE;
  - clear ERR and job index j; →RREQ.
- RREQ: wait for READ_BUSY=0, then pulse READ_REQ for exactly 1 cycle.
  - READ_ADDR=ra; READ_COUNT=2·SRC_N.
  - Word counter w←0; →READ.
- READ:
  - READ_READY=1. A word is accepted when READ_VALID=1.
  - Word w with w even asserts COMP_WE[w/2]; w odd asserts SEED_WE[w/2], in the same cycle as acceptance.
  - After word 2·SRC_N−1: CNT_CLR pulses 1 cycle; c←0.
  - If len==0: set ERR, skip PROC, go directly to WREQ (counters report 0). Otherwise →PROC.
- PROC: PROC_EN=1 for exactly len consecutive cycles; no backpressure; then →WREQ.
- WREQ: wait for WRITE_BUSY=0, then pulse WRITE_REQ for 1 cycle.
  - WRITE_ADDR=wa; WRITE_COUNT=DST_N; →WRITE.
- WRITE:
  - WRITE_VALID=1; WRITE_DATA=DST_DATA.
  - Each cycle with WRITE_READY=1 is a beat: DST_SHIFT=1.
  - After DST_N beats →NEXT.
- NEXT (1 cycle):
  - ra←ra+8·SRC_N; wa←wa+4·DST_N; j←j+1.
  - →RREQ if j+1<jobs, else →FINI.
  - Address arithmetic is mod 2^32 (wraps silently).
- FINI: DONE=0; wait for GO=0, then →IDLE. GO held high never restarts a batch.
- Invariants:
  - COMP_WE/SEED_WE are one-hot or zero.
  - PROC_EN and DST_SHIFT are never asserted together.
  - READ_REQ and WRITE_REQ are never asserted in the same cycle.
- SIZE/BATCH/SRC/DST changing after GO is accepted has no effect; all are latched.
- SNG_DATA=READ_DATA combinationally.

Test Plan:
- SRC_N=4, DST_N=2, SIZE=16, BATCH=1, no stalls:
  - exactly 1 READ_REQ with count 8; 8 strobes in order C0,S0…C3,S3;
  - 16 PROC_EN cycles; 1 WRITE_REQ with count 2 and 2 shifts;
  - DONE returns after GO drops.
- BATCH=3, SRC=0x1000, DST=0x2000:
  - READ_ADDR sequence 0x1000, 0x1020, 0x1040;
  - WRITE_ADDR sequence 0x2000, 0x2008, 0x2010;
  - 3× CNT_CLR.
- BATCH=0 → runs as exactly 1 job. SIZE=0 → no PROC_EN cycles, ERR=1 at FINI, 2 words still written; next GO clears ERR.
- Backpressure:
  - READ_BUSY high for 5 cycles delays READ_REQ by 5 cycles.
  - READ_VALID toggling 1/0 gives strobes only on valid cycles.
  - WRITE_READY low for 3 cycles holds WRITE_DATA with no DST_SHIFT.
- GO held high through FINI: no second job; drop GO → IDLE in 1 cycle.
- Assert RST mid-PROC (cycle 7 of 16): next edge all outputs 0, DONE=1; a fresh GO runs a full job correctly.
- SRC=0xFFFFFFF0, BATCH=2, SRC_N=4 → second READ_ADDR=0x00000010 (wrap).
